// File: rtl/insn_fetch_queue_pkg.sv
// Shared front-end types: machine widths, the fetch-queue entry and the decoded uop record.
// The fetch queue carries fetch_entry_t; uop_t is what decode produces from it.
package insn_fetch_queue_pkg;

  localparam int unsigned M_WIDTH   = 32;
  localparam int unsigned LG_PHT_SZ = 12;

  typedef struct packed {
    logic [31:0]          insn;
    logic [M_WIDTH-1:0]   pc;
    logic                 pred;
    logic [LG_PHT_SZ-1:0] pht_idx;
    logic [M_WIDTH-1:0]   pred_target;
`ifdef ENABLE_CYCLE_ACCOUNTING
    logic [63:0]          fetch_cycle;
`endif
  } fetch_entry_t;

  typedef enum logic [3:0] {
    OpAlu,
    OpAluImm,
    OpLoad,
    OpStore,
    OpBranch,
    OpJal,
    OpJalr,
    OpLui,
    OpAuipc,
    OpSystem,
    OpIllegal
  } uop_op_e;

  typedef struct packed {
    uop_op_e              op;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [4:0]           rd;
    logic [31:0]          imm;
    logic [M_WIDTH-1:0]   pc;
    logic                 pred;
    logic [LG_PHT_SZ-1:0] pht_idx;
    logic [M_WIDTH-1:0]   pred_target;
  } uop_t;

endpackage

// File: rtl/insn_fetch_queue.sv
// Decoupling FIFO between fetch and decode. Registered storage, one-cycle enq-to-deq latency,
// flush has priority over any same-cycle traffic.
module insn_fetch_queue
  import insn_fetch_queue_pkg::*;
#(
  parameter int unsigned LG_Q_ENTRIES = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    enq_valid,
  output logic                    enq_ready,
  input  logic [31:0]             enq_insn,
  input  logic [M_WIDTH-1:0]      enq_pc,
  input  logic                    enq_pred,
  input  logic [LG_PHT_SZ-1:0]    enq_pht_idx,
  input  logic [M_WIDTH-1:0]      enq_pred_target,
  output logic                    deq_valid,
  input  logic                    deq_ready,
  output logic [31:0]             insn,
  output logic [M_WIDTH-1:0]      pc,
  output logic                    insn_pred,
  output logic [LG_PHT_SZ-1:0]    pht_idx,
  output logic [M_WIDTH-1:0]      insn_pred_target,
`ifdef ENABLE_CYCLE_ACCOUNTING
  input  logic [63:0]             enq_fetch_cycle,
  output logic [63:0]             fetch_cycle,
`endif
  output logic [LG_Q_ENTRIES:0]   occupancy
);

  localparam int unsigned QEntries = 1 << LG_Q_ENTRIES;

  typedef logic [LG_Q_ENTRIES:0] ptr_t;

  ptr_t         head_q, head_d;
  ptr_t         tail_q, tail_d;
  fetch_entry_t mem_q [QEntries];
  fetch_entry_t wr_entry;
  fetch_entry_t rd_entry;
  logic         full;
  logic         empty;
  logic         enq_fire;
  logic         deq_fire;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    empty    = (head_q == tail_q);
    full     = (head_q[LG_Q_ENTRIES-1:0] == tail_q[LG_Q_ENTRIES-1:0]) &&
               (head_q[LG_Q_ENTRIES] != tail_q[LG_Q_ENTRIES]);
    enq_fire = enq_valid && !full && !flush;
    deq_fire = deq_ready && !empty && !flush;
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (enq_fire) tail_d = tail_q + ptr_t'(1);
      if (deq_fire) head_d = head_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_comb begin
    wr_entry             = '0;
    wr_entry.insn        = enq_insn;
    wr_entry.pc          = enq_pc;
    wr_entry.pred        = enq_pred;
    wr_entry.pht_idx     = enq_pht_idx;
    wr_entry.pred_target = enq_pred_target;
`ifdef ENABLE_CYCLE_ACCOUNTING
    wr_entry.fetch_cycle = enq_fetch_cycle;
`endif
  end

  // Storage is intentionally left out of reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (enq_fire) mem_q[tail_q[LG_Q_ENTRIES-1:0]] <= wr_entry;
  end

  always_comb begin
    rd_entry         = mem_q[head_q[LG_Q_ENTRIES-1:0]];
    insn             = rd_entry.insn;
    pc               = rd_entry.pc;
    insn_pred        = rd_entry.pred;
    pht_idx          = rd_entry.pht_idx;
    insn_pred_target = rd_entry.pred_target;
`ifdef ENABLE_CYCLE_ACCOUNTING
    fetch_cycle      = rd_entry.fetch_cycle;
`endif
  end

  always_comb begin
    enq_ready = !full;
    deq_valid = !empty;
    occupancy = tail_q - head_q;
  end

endmodule

// File: tb/tb_insn_fetch_queue.sv
// Scoreboard bench for insn_fetch_queue: driver pushes expected entries from a count-based model,
// a negedge monitor pops and compares whenever the DUT dequeues.
module tb_insn_fetch_queue;
  import insn_fetch_queue_pkg::*;

  localparam int Depth = 8;

  logic                 clk;
  logic                 reset_n;
  logic                 flush;
  logic                 enq_valid;
  logic                 enq_ready;
  logic [31:0]          enq_insn;
  logic [M_WIDTH-1:0]   enq_pc;
  logic                 enq_pred;
  logic [LG_PHT_SZ-1:0] enq_pht_idx;
  logic [M_WIDTH-1:0]   enq_pred_target;
  logic                 deq_valid;
  logic                 deq_ready;
  logic [31:0]          insn;
  logic [M_WIDTH-1:0]   pc;
  logic                 insn_pred;
  logic [LG_PHT_SZ-1:0] pht_idx;
  logic [M_WIDTH-1:0]   insn_pred_target;
  logic [3:0]           occupancy;

  insn_fetch_queue #(.LG_Q_ENTRIES(3)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .flush            (flush),
    .enq_valid        (enq_valid),
    .enq_ready        (enq_ready),
    .enq_insn         (enq_insn),
    .enq_pc           (enq_pc),
    .enq_pred         (enq_pred),
    .enq_pht_idx      (enq_pht_idx),
    .enq_pred_target  (enq_pred_target),
    .deq_valid        (deq_valid),
    .deq_ready        (deq_ready),
    .insn             (insn),
    .pc               (pc),
    .insn_pred        (insn_pred),
    .pht_idx          (pht_idx),
    .insn_pred_target (insn_pred_target),
    .occupancy        (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  fetch_entry_t exp_q[$];
  int           mdl_cnt  = 0;
  int           exp_occ  = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic fetch_entry_t mk(input logic [31:0] i, input logic [M_WIDTH-1:0] p,
                                      input logic pr, input logic [LG_PHT_SZ-1:0] h,
                                      input logic [M_WIDTH-1:0] t);
    fetch_entry_t e;
    e = '0;
    e.insn = i;
    e.pc = p;
    e.pred = pr;
    e.pht_idx = h;
    e.pred_target = t;
    return e;
  endfunction

  // One cycle of stimulus; the model is just an entry count and the ordered expected list.
  task automatic drive(input logic ev, input logic ed, input logic fl, input fetch_entry_t e);
    bit acc;
    bit take;
    @(posedge clk);
    #1;
    enq_valid       = ev;
    deq_ready       = ed;
    flush           = fl;
    enq_insn        = e.insn;
    enq_pc          = e.pc;
    enq_pred        = e.pred;
    enq_pht_idx     = e.pht_idx;
    enq_pred_target = e.pred_target;
    exp_occ = mdl_cnt;
    if (fl) begin
      mdl_cnt = 0;
    end else begin
      acc  = ev && (mdl_cnt < Depth);
      take = ed && (mdl_cnt > 0);
      if (acc) exp_q.push_back(e);
      mdl_cnt = mdl_cnt + int'(acc) - int'(take);
    end
  endtask

  task automatic idle(input logic ed);
    drive(1'b0, ed, 1'b0, mk(32'h0, '0, 1'b0, '0, '0));
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    flush     = 1'b0;
    reset_n   = 1'b0;
    #1;
    chk("reset_immediate_deq_valid", 64'(deq_valid), 64'd0);
    chk("reset_immediate_occupancy", 64'(occupancy), 64'd0);
    exp_occ = 0;
    mdl_cnt = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Monitor: handshake/occupancy every cycle, head fields whenever a dequeue fires.
  always @(negedge clk) begin
    fetch_entry_t h;
    if (!reset_n) begin
      chk("in_reset_deq_valid", 64'(deq_valid), 64'd0);
      chk("in_reset_occupancy", 64'(occupancy), 64'd0);
      exp_q.delete();
    end else begin
      chk("occupancy", 64'(occupancy), 64'(exp_occ));
      chk("enq_ready", 64'(enq_ready), 64'(exp_occ != Depth));
      chk("deq_valid", 64'(deq_valid), 64'(exp_occ != 0));
      if (flush) begin
        exp_q.delete();
      end else if (deq_valid && deq_ready) begin
        if (exp_q.size() == 0) begin
          chk("deq_with_empty_scoreboard", 64'd1, 64'd0);
        end else begin
          h = exp_q.pop_front();
          chk("insn", 64'(insn), 64'(h.insn));
          chk("pc", 64'(pc), 64'(h.pc));
          chk("insn_pred", 64'(insn_pred), 64'(h.pred));
          chk("pht_idx", 64'(pht_idx), 64'(h.pht_idx));
          chk("insn_pred_target", 64'(insn_pred_target), 64'(h.pred_target));
        end
      end
    end
  end

  initial begin
    logic [31:0] r0, r1, r2, r3;
    reset_n = 1'b1;
    flush = 1'b0;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    enq_insn = '0;
    enq_pc = '0;
    enq_pred = 1'b0;
    enq_pht_idx = '0;
    enq_pred_target = '0;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    idle(1'b1);

    // First enqueue after reset, visible one cycle later.
    drive(1'b1, 1'b0, 1'b0, mk(32'h0000_0013, 32'h1000, 1'b0, 12'h0, 32'h0));
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);

    // Fill, attempt a ninth, then drain in order.
    for (int i = 0; i < 9; i++)
      drive(1'b1, 1'b0, 1'b0, mk(32'h100 + 32'(i), 32'h4000 + 32'(4 * i), i[0], 12'(i), 32'h0));
    for (int i = 0; i < 9; i++) idle(1'b1);

    // Full with enq and deq together: only the deq takes effect.
    for (int i = 0; i < 8; i++)
      drive(1'b1, 1'b0, 1'b0, mk(32'h200 + 32'(i), 32'h5000 + 32'(4 * i), 1'b1, 12'(i), 32'h77));
    drive(1'b1, 1'b1, 1'b0, mk(32'hdead_beef, 32'h6000, 1'b0, 12'h0, 32'h0));
    idle(1'b0);
    for (int i = 0; i < 8; i++) idle(1'b1);

    // Flush with three entries and simultaneous enq/deq.
    for (int i = 0; i < 3; i++)
      drive(1'b1, 1'b0, 1'b0, mk(32'h300 + 32'(i), 32'h7000 + 32'(4 * i), 1'b0, 12'(i), 32'h0));
    drive(1'b1, 1'b1, 1'b1, mk(32'hbad0_0001, 32'h7100, 1'b1, 12'h5, 32'h0));
    idle(1'b1);
    idle(1'b1);

    // Streaming across pointer wrap, occupancy stays at one.
    drive(1'b1, 1'b0, 1'b0, mk(32'h0000_0013, 32'h2000, 1'b0, 12'd0, 32'h0));
    for (int i = 1; i < 20; i++)
      drive(1'b1, 1'b1, 1'b0, mk(32'h0000_0013 + 32'(i << 7), 32'h2000 + 32'(4 * i), i[0],
                                 12'(i), 32'h2100 + 32'(i)));
    idle(1'b1);
    idle(1'b1);

    // Asynchronous reset with five entries queued.
    for (int i = 0; i < 5; i++)
      drive(1'b1, 1'b0, 1'b0, mk(32'h500 + 32'(i), 32'h8000 + 32'(4 * i), 1'b0, 12'(i), 32'h0));
    reset_pulse();
    drive(1'b1, 1'b0, 1'b0, mk(32'h0000_0093, 32'h3000, 1'b1, 12'h3, 32'h3300));
    drive(1'b1, 1'b0, 1'b0, mk(32'h0000_0113, 32'h3004, 1'b0, 12'h4, 32'h0));
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      r0 = $urandom;
      r1 = $urandom;
      r2 = $urandom;
      r3 = $urandom;
      drive(r0[1:0] != 2'b00, r0[3:2] != 2'b00 || r0[4], r0[9:5] == 5'd0,
            mk(r1, r2[M_WIDTH-1:0], r3[0], r3[LG_PHT_SZ:1], r3 ^ r1));
    end
    for (int i = 0; i < 10; i++) idle(1'b1);

    @(negedge clk);
    #1;
    chk("drain_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_occupancy", 64'(occupancy), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/insn_fetch_queue.md
INSN_FETCH_QUEUE -- requirements
Module: insn_fetch_queue

Interface
REQ-001 SHALL have parameter LG_Q_ENTRIES, default 3, log2 of queue depth (8 entries).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port flush  input  1  discard all entries (mispredict/restart).
REQ-005 SHALL have port enq_valid  input  1  fetch presents an instruction.
REQ-006 SHALL have port enq_ready  output  1  queue accepts enq this cycle.
REQ-007 SHALL have port enq_insn  input  32  raw RISC-V instruction word.
REQ-008 SHALL have port enq_pc  input  M_WIDTH  instruction PC.
REQ-009 SHALL have port enq_pred  input  1  predictor taken bit.
REQ-010 SHALL have port enq_pht_idx  input  LG_PHT_SZ  PHT index used for prediction.
REQ-011 SHALL have port enq_pred_target  input  M_WIDTH  predicted target (jalr/ret).
REQ-012 SHALL have ports deq_valid output 1 and deq_ready input 1, the decode-side handshake.
REQ-013 SHALL have ports insn, pc, insn_pred, pht_idx, insn_pred_target  output, widths as REQ-007..011, carrying the head entry to the decoder.
REQ-014 SHALL have port occupancy  output  LG_Q_ENTRIES+1  current entry count.
REQ-015 SHALL, under ENABLE_CYCLE_ACCOUNTING only, add enq_fetch_cycle input 64 and fetch_cycle output 64, stored per entry.

Function
REQ-016 SHALL be a circular FIFO of 2^LG_Q_ENTRIES entries with head/tail pointers one bit wider than the index; full when indices equal and MSBs differ, empty when pointers equal.
REQ-017 SHALL drive enq_ready = !full, independent of deq_ready (no combinational deq->enq path).
REQ-018 SHALL write an entry at tail and advance tail when enq_valid && enq_ready.
REQ-019 SHALL drive deq_valid = !empty and the output fields combinationally from the head entry.
REQ-020 SHALL advance head when deq_valid && deq_ready; output fields are don't-care when deq_valid=0.
REQ-021 SHALL have latency 1: an entry enqueued in cycle t is first visible with deq_valid=1 in cycle t+1; no same-cycle bypass.
REQ-022 SHALL handle simultaneous enq and deq when neither full nor empty: both pointers advance, occupancy unchanged.
REQ-023 SHALL, when full, reject enq even if deq fires in the same cycle; occupancy decrements by one.
REQ-024 SHALL, when empty, ignore deq_ready.
REQ-025 SHALL wrap pointers modulo 2^(LG_Q_ENTRIES+1) without loss or duplication.
REQ-026 SHALL give flush priority: on flush, head=tail=0 next cycle and any same-cycle enq/deq is discarded (no write, head not credited).
REQ-027 SHALL keep occupancy = tail - head, equal to 0 after flush or reset.

Reset
REQ-028 SHALL, on reset_n low (asynchronous), clear head, tail, occupancy, deq_valid to 0 and drive enq_ready to 1 after release.
REQ-029 SHALL not reset the entry storage array; outputs other than handshakes are don't-care while empty.
REQ-030 SHALL, on reset asserted mid-operation, drop all entries; the first enq after release is the first dequeued.

Structure
REQ-031 SHALL define the entry typedef fetch_entry_t (insn, pc, pred, pht_idx, pred_target, optional fetch_cycle) in the shared package alongside uop_t; M_WIDTH and LG_PHT_SZ come from the existing machine header.
REQ-032 SHALL be a single module with no sub-modules; storage is an inferred register array.

Verification
REQ-033 SHALL cover: after reset, enq insn=0x00000013 pc=0x1000 -> next cycle deq_valid=1, insn=0x00000013, pc=0x1000, occupancy=1.
REQ-034 SHALL cover: 8 enqs with deq_ready=0 -> enq_ready=0, occupancy=8; 9th enq dropped; then 8 deqs return the 8 in order, deq_valid=0 after.
REQ-035 SHALL cover: full queue, enq_valid=1 and deq_ready=1 same cycle -> occupancy 8->7, enq not accepted.
REQ-036 SHALL cover: occupancy=3, flush with enq_valid=1 and deq_ready=1 -> next cycle occupancy=0, deq_valid=0, enq_ready=1.
REQ-037 SHALL cover: 20 back-to-back enq/deq with pc=0x2000+4*i, pred alternating, pht_idx=i -> outputs match in order across pointer wrap, occupancy steady at 1.
REQ-038 SHALL cover: reset_n pulsed low mid-stream with occupancy=5 -> immediately deq_valid=0, occupancy=0; next enq pc=0x3000 dequeued first.
